// File: rtl/coord_cmd_loader.sv
// SPI-style serial command loader: receives 16-bit words, queues them in a 2-entry FIFO and
// issues each one to coord_control as a single-cycle ctrl/value pulse. Optional COORD_CMD_VBLANK_SYNC_EN.
module coord_cmd_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    input  logic        vblank,
    output logic [2:0]  ctrl,
    output logic [12:0] value,
    output logic        cmd_pending,
    output logic        ovf_err,
    output logic        frame_err
);

    localparam logic [2:0] CTRL_NONE = 3'b011;
    // Synchroniser reset values, ordered {cs_n, mosi, sck}.
    localparam logic [2:0] SYNC_RST  = 3'b100;

    logic [2:0] sync_in;
    logic [2:0] sync_bit;

    assign sync_in = {spi_cs_n, spi_mosi, spi_sck};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic stage_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg  <= SYNC_RST[gi];
                    stage_reg <= SYNC_RST[gi];
                end else begin
                    meta_reg  <= sync_in[gi];
                    stage_reg <= meta_reg;
                end
            end
            assign sync_bit[gi] = stage_reg;
        end
    endgenerate

    logic sck_s, mosi_s, cs_n_s;
    assign sck_s  = sync_bit[0];
    assign mosi_s = sync_bit[1];
    assign cs_n_s = sync_bit[2];

    logic        sck_prev_reg;
    logic        cs_prev_reg;
    logic [1:0]  settle_reg;
    logic        armed_reg;
    logic        in_word_reg;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt_reg;

    logic sck_rise, cs_fall, cs_rise;
    logic word_start, word_end, shift_en;
    logic push_req, bad_frame;

    assign sck_rise   = sck_s & ~sck_prev_reg;
    assign cs_fall    = cs_prev_reg & ~cs_n_s;
    assign cs_rise    = ~cs_prev_reg & cs_n_s;
    // A word only counts if its cs_n fall was seen after the synchronisers carried real samples,
    // so a word already in flight when reset releases is silently discarded.
    assign word_start = cs_fall & armed_reg;
    assign shift_en   = sck_rise & ~cs_n_s & (in_word_reg | word_start);
    assign word_end   = cs_rise & in_word_reg;
    assign push_req   = word_end & (bit_cnt_reg == 5'd16);
    assign bad_frame  = word_end & (bit_cnt_reg != 5'd0) & (bit_cnt_reg != 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_reg <= 1'b0;
            cs_prev_reg  <= 1'b1;
            settle_reg   <= 2'd0;
            armed_reg    <= 1'b0;
            in_word_reg  <= 1'b0;
            shift_reg    <= 16'd0;
            bit_cnt_reg  <= 5'd0;
        end else begin
            sck_prev_reg <= sck_s;
            cs_prev_reg  <= cs_n_s;
            if (settle_reg != 2'd2)
                settle_reg <= settle_reg + 2'd1;
            if (settle_reg == 2'd2 && cs_n_s)
                armed_reg <= 1'b1;
            if (word_start)
                in_word_reg <= 1'b1;
            else if (cs_rise)
                in_word_reg <= 1'b0;
            if (shift_en)
                shift_reg <= {shift_reg[14:0], mosi_s};
            if (word_start)
                bit_cnt_reg <= shift_en ? 5'd1 : 5'd0;
            else if (shift_en && bit_cnt_reg != 5'd17)
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
        end
    end

    logic issue_gate;
`ifdef COORD_CMD_VBLANK_SYNC_EN
    assign issue_gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign issue_gate    = 1'b1;
`endif

    logic [15:0] mem_reg [0:1];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  fifo_cnt_reg;
    logic        pop, push_ok, ovf_set, flag_clr;
    logic [15:0] head;

    assign pop         = (fifo_cnt_reg != 2'd0) & issue_gate;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_ok     = push_req & ((fifo_cnt_reg != 2'd2) | pop);
    assign ovf_set     = push_req & ~push_ok;
    assign head        = mem_reg[rd_ptr_reg];
    assign flag_clr    = pop & (head[15:13] == CTRL_NONE) & head[0];
    assign cmd_pending = (fifo_cnt_reg != 2'd0);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_reg[wr_ptr_reg] <= shift_reg;
    end

    logic [2:0]  ctrl_reg;
    logic [12:0] value_reg;
    logic        ovf_reg;
    logic        frame_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            fifo_cnt_reg <= 2'd0;
            ctrl_reg     <= CTRL_NONE;
            value_reg    <= 13'd0;
            ovf_reg      <= 1'b0;
            frame_reg    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({push_ok, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
            ctrl_reg  <= pop ? head[15:13] : CTRL_NONE;
            value_reg <= pop ? head[12:0]  : 13'd0;
            // Set wins over a clear issued in the same cycle.
            ovf_reg   <= ovf_set   | (ovf_reg   & ~flag_clr);
            frame_reg <= bad_frame | (frame_reg & ~flag_clr);
        end
    end

    assign ctrl      = ctrl_reg;
    assign value     = value_reg;
    assign ovf_err   = ovf_reg;
    assign frame_err = frame_reg;

endmodule

// File: tb/tb_coord_cmd_loader.sv
// Directed bench for coord_cmd_loader; issued words are matched against a scoreboard queue.
// Vblank hold and overflow steps run only when COORD_CMD_VBLANK_SYNC_EN is defined.
module tb_coord_cmd_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        vblank = 1'b1;
    logic [2:0]  ctrl;
    logic [12:0] value;
    logic        cmd_pending;
    logic        ovf_err;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int last_issue_cyc = -1;
    int rise_cyc = 0;
    int n0 = 0;
    int vb_cyc = 0;
    logic [15:0] sb_q[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coord_cmd_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .vblank      (vblank),
        .ctrl        (ctrl),
        .value       (value),
        .cmd_pending (cmd_pending),
        .ovf_err     (ovf_err),
        .frame_err   (frame_err)
    );

    // Any non-idle output is an issue and must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && (ctrl !== 3'b011 || value !== 13'd0)) begin
            issue_cnt++;
            last_issue_cyc = cyc;
            checks++;
            assert (sb_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_issue observed=%b/%h required=none", ctrl, value);
            end
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                checks++;
                assert ({ctrl, value} === mon_exp) else begin
                    failures++;
                    $error("FAIL issue_word observed=%h required=%h", {ctrl, value}, mon_exp);
                end
                $display("issue cyc=%0d word=%h", cyc, {ctrl, value});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h required=%0h", tag, obs, exp);
    endtask

    task automatic lower_cs();
        #1 spi_cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            #1 spi_mosi = (i < 16) ? w[15 - i] : 1'b0;
            repeat (3) @(posedge clk);
            #1 spi_sck = 1'b1;
            repeat (3) @(posedge clk);
            #1 spi_sck = 1'b0;
        end
    endtask

    task automatic raise_cs();
        repeat (3) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        rise_cyc = cyc;
        repeat (8) @(posedge clk);
    endtask

    task automatic send(input logic [15:0] w, input int n);
        lower_cs();
        shift_bits(w, n);
        raise_cs();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", ctrl, 3'b011);
        chk("reset_value", value, 0);
        chk("reset_pending", cmd_pending, 0);
        chk("reset_ovf", ovf_err, 0);
        chk("reset_frame", frame_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);

        // Basic word and its latency from the synchronised cs_n rise.
        sb_q.push_back(16'h2FA0);
        send(16'h2FA0, 16);
        chk("basic_latency", last_issue_cyc, rise_cyc + 4);
        chk("basic_count", issue_cnt, 1);
        @(negedge clk);
        chk("idle_ctrl", ctrl, 3'b011);
        chk("idle_value", value, 0);

        // Short frame, then the clear command.
        send(16'hFFFF, 15);
        @(negedge clk);
        chk("short_frame_err", frame_err, 1);
        chk("short_no_issue", issue_cnt, 1);
        sb_q.push_back(16'h6001);
        send(16'h6001, 16);
        @(negedge clk);
        chk("clear_frame", frame_err, 0);
        chk("clear_ovf", ovf_err, 0);
        chk("clear_count", issue_cnt, 2);

        // Long frame saturates the counter and is rejected.
        send(16'h1234, 18);
        @(negedge clk);
        chk("long_frame_err", frame_err, 1);
        chk("long_no_issue", issue_cnt, 2);
        sb_q.push_back(16'h6001);
        send(16'h6001, 16);
        @(negedge clk);
        chk("clear2_frame", frame_err, 0);

`ifdef COORD_CMD_VBLANK_SYNC_EN
        // Hold two words while vblank is low, then release back-to-back.
        vblank = 1'b0;
        n0 = issue_cnt;
        sb_q.push_back(16'hA001);
        sb_q.push_back(16'hC002);
        send(16'hA001, 16);
        send(16'hC002, 16);
        @(negedge clk);
        chk("hold_pending", cmd_pending, 1);
        chk("hold_no_issue", issue_cnt, n0);
        @(posedge clk);
        #1 vblank = 1'b1;
        vb_cyc = cyc;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("release_count", issue_cnt, n0 + 2);
        chk("release_b2b", last_issue_cyc, vb_cyc + 2);
        chk("release_pending", cmd_pending, 0);

        // Third word overflows the 2-entry FIFO.
        vblank = 1'b0;
        n0 = issue_cnt;
        sb_q.push_back(16'h1111);
        sb_q.push_back(16'h2222);
        send(16'h1111, 16);
        send(16'h2222, 16);
        send(16'h3333, 16);
        @(negedge clk);
        chk("ovf_set", ovf_err, 1);
        chk("ovf_no_issue", issue_cnt, n0);
        @(posedge clk);
        #1 vblank = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("ovf_issue_count", issue_cnt, n0 + 2);
        sb_q.push_back(16'h6001);
        send(16'h6001, 16);
        @(negedge clk);
        chk("ovf_cleared", ovf_err, 0);
`endif

        // cs_n pulse without sck edges.
        n0 = issue_cnt;
        lower_cs();
        raise_cs();
        @(negedge clk);
        chk("empty_frame_err", frame_err, 0);
        chk("empty_no_issue", issue_cnt, n0);
        chk("empty_pending", cmd_pending, 0);

        // Reset mid-word, released while cs_n is still low.
        send(16'h5555, 15);
        @(negedge clk);
        chk("pre_reset_frame", frame_err, 1);
        lower_cs();
        shift_bits(16'hA5A5, 8);
        #2 rst_n = 1'b0;
        #2;
        chk("rst_mid_ctrl", ctrl, 3'b011);
        chk("rst_mid_value", value, 0);
        chk("rst_mid_frame", frame_err, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        shift_bits(16'h5A00, 8);
        raise_cs();
        @(negedge clk);
        chk("inflight_frame", frame_err, 0);
        chk("inflight_no_issue", issue_cnt, n0);
        chk("inflight_pending", cmd_pending, 0);
        sb_q.push_back(16'h4ABC);
        send(16'h4ABC, 16);
        @(negedge clk);
        chk("post_reset_count", issue_cnt, n0 + 1);
        chk("post_reset_frame", frame_err, 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coord_cmd_loader.md
COORD_CMD_LOADER -- requirements
Module: coord_cmd_loader

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port spi_sck  input  1  host serial clock; asynchronous to clk.
REQ-004 SHALL have port spi_mosi  input  1  host serial data, MSB first, sampled on spi_sck rising.
REQ-005 SHALL have port spi_cs_n  input  1  host word framing; low = word in progress.
REQ-006 SHALL have port vblank  input  1  high while the frame is not being rendered (safe update window).
REQ-007 SHALL have port ctrl  output  3  command code to coord_control; 3'b011 (NONE) when idle.
REQ-008 SHALL have port value  output  13  command operand to coord_control; 0 when idle.
REQ-009 SHALL have port cmd_pending  output  1  high while the command FIFO is non-empty.
REQ-010 SHALL have port ovf_err  output  1  sticky; a received word was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  sticky; a word was framed with a bit count other than 16.

Function
REQ-012 SHALL pass spi_sck, spi_mosi and spi_cs_n each through a 2-flop synchroniser; all following refers to synchronised signals.
REQ-013 SHALL detect sck rising edges (registered previous value) and, while cs_n is low, shift mosi into a 16-bit shift register MSB first.
REQ-014 SHALL keep a bit counter 0..17, saturating at 17, cleared on the cs_n falling edge.
REQ-015 On the cs_n rising edge, count==16 SHALL push the word {ctrl[15:13], value[12:0]} into the FIFO; count==0 SHALL be ignored; any other count SHALL set frame_err and drop the word.
REQ-016 The FIFO SHALL have 2 entries; a push while full (with no pop in the same cycle) SHALL drop the new word and set ovf_err.
REQ-017 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-018 Issue rule: when the FIFO is non-empty and the issue gate is open (see Configuration), the head entry SHALL be popped, and ctrl/value SHALL be registered from it for exactly one clk cycle.
REQ-019 Back-to-back issue SHALL be allowed: two queued entries appear on consecutive cycles.
REQ-020 In every cycle with no issue, ctrl SHALL be 3'b011 and value SHALL be 0.
REQ-021 Latency (gate open): ctrl/value SHALL be valid on the 2nd clk cycle after the cycle in which the synchronised cs_n rise is detected.
REQ-022 An issued word with ctrl==3'b011 and value[0]==1 SHALL clear ovf_err and frame_err on the cycle it is output; set and clear in the same cycle resolves to set.
REQ-023 cmd_pending SHALL be combinationally derived from the FIFO occupancy count (non-zero).
REQ-024 A cs_n rise while sck is also toggling SHALL use the bit count as of the cs_n rising edge; sck edges with cs_n high SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately clear: the FIFO (empty), the shift register, the bit counter, ovf_err and frame_err; it SHALL also set ctrl=3'b011 and value=0.
REQ-026 The synchronisers SHALL reset to sck=0, mosi=0, cs_n=1, so that a word in flight at reset is discarded without setting frame_err.
REQ-027 After reset, the first word SHALL require a fresh cs_n falling edge.

Configuration
REQ-028 Macro COORD_CMD_VBLANK_SYNC_EN: when defined, the issue gate SHALL equal vblank, so queued commands are held while vblank is low.
REQ-029 Without COORD_CMD_VBLANK_SYNC_EN, the issue gate SHALL always be open, vblank SHALL be unused, and behaviour is otherwise identical.

Verification
REQ-030 Reset, gate open; send 16 bits 0x2FA0 -> one cycle ctrl=3'b001, value=13'h0FA0; otherwise ctrl=3'b011, value=0.
REQ-031 Macro defined, vblank=0; send 0xA001 then 0xC002 -> cmd_pending=1 with no issue; raise vblank -> ctrl=3'b101/value=1, then next cycle 3'b110/value=2; cmd_pending falls.
REQ-032 Macro defined, vblank=0; send three words -> ovf_err=1; only the first two issue once vblank rises.
REQ-033 Frame 15 bits -> frame_err=1, nothing issued; then send 0x6001 -> both flags cleared and ctrl=3'b011 pulse (value=1).
REQ-034 Assert rst_n low mid-word (8 bits shifted) -> outputs idle, flags 0; the next full 16-bit word issues correctly.
REQ-035 cs_n pulsed low/high with no sck edges -> no push and no flag set.
